// File: rtl/reset_ce_seq.sv
`default_nettype none
// ============================================================================
//  Module      : reset_ce_seq
//  Description : Core reset sequencer for a PLL-clocked game core.
//                The lock input is synchronized. core_reset is released only
//                after the lock has been stable for LOCK_HOLD cycles. The
//                block also generates the ce_a/ce_b clock enables, which are
//                active only while the core runs, and counts lock losses that
//                occur while the core runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_ce_seq #(
  parameter int LOCK_HOLD = 1024,
  parameter int CE_DIV_A  = 4,
  parameter int CE_DIV_B  = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       ext_reset,
  output logic       core_reset,
  output logic       running,
  output logic       ce_a,
  output logic       ce_b,
  output logic [7:0] lock_loss_cnt
);

  // Counter widths never collapse to zero bits, even when a divisor is 1.
  localparam int HOLD_W  = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam int DIV_A_W = (CE_DIV_A > 1) ? $clog2(CE_DIV_A) : 1;
  localparam int DIV_B_W = (CE_DIV_B > 1) ? $clog2(CE_DIV_B) : 1;

  localparam logic [HOLD_W-1:0]  c_hold_last  = HOLD_W'(LOCK_HOLD - 1);
  localparam logic [DIV_A_W-1:0] c_div_a_last = DIV_A_W'(CE_DIV_A - 1);
  localparam logic [DIV_B_W-1:0] c_div_b_last = DIV_B_W'(CE_DIV_B - 1);
  // A divisor of 1 means the enable is already high in the first RUN cycle.
  localparam logic c_ce_a_first = (CE_DIV_A == 1);
  localparam logic c_ce_b_first = (CE_DIV_B == 1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_COUNT = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_lock_meta;
  logic                r_lock_s;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [DIV_A_W-1:0]  r_div_a;
  logic [DIV_B_W-1:0]  r_div_b;
  logic                r_core_reset;
  logic                r_running;
  logic                r_ce_a;
  logic                r_ce_b;
  logic [7:0]          r_lock_loss_cnt;

  logic                w_good;
  logic [DIV_A_W-1:0]  w_div_a_nxt;
  logic [DIV_B_W-1:0]  w_div_b_nxt;

  // The core may run only while the lock is present and no reset is requested.
  assign w_good      = r_lock_s & ~ext_reset;
  assign w_div_a_nxt = (r_div_a == c_div_a_last) ? '0 : r_div_a + 1'b1;
  assign w_div_b_nxt = (r_div_b == c_div_b_last) ? '0 : r_div_b + 1'b1;

  // Two-flop synchronizer; no other logic samples pll_locked.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Sequencer FSM. Outputs are registered and change on the same edge as the state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state         <= S_HOLD;
      r_hold_cnt      <= '0;
      r_div_a         <= '0;
      r_div_b         <= '0;
      r_core_reset    <= 1'b1;
      r_running       <= 1'b0;
      r_ce_a          <= 1'b0;
      r_ce_b          <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      unique case (r_state)
        S_HOLD: begin
          r_hold_cnt <= '0;
          if (w_good) begin
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!w_good) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == c_hold_last) begin
            r_state      <= S_RUN;
            r_hold_cnt   <= '0;
            r_core_reset <= 1'b0;
            r_running    <= 1'b1;
            r_ce_a       <= c_ce_a_first;
            r_ce_b       <= c_ce_b_first;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!w_good) begin
            r_state      <= S_HOLD;
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_ce_a       <= 1'b0;
            r_ce_b       <= 1'b0;
            // Only a lock loss is counted. A simultaneous ext_reset still counts once.
            if (!r_lock_s && (r_lock_loss_cnt != 8'hFF)) begin
              r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
            end
          end else begin
            r_div_a <= w_div_a_nxt;
            r_div_b <= w_div_b_nxt;
            r_ce_a  <= (w_div_a_nxt == c_div_a_last);
            r_ce_b  <= (w_div_b_nxt == c_div_b_last);
          end
        end
        default: begin
          r_state      <= S_HOLD;
          r_hold_cnt   <= '0;
          r_div_a      <= '0;
          r_div_b      <= '0;
          r_core_reset <= 1'b1;
          r_running    <= 1'b0;
          r_ce_a       <= 1'b0;
          r_ce_b       <= 1'b0;
        end
      endcase
    end
  end

  assign core_reset    = r_core_reset;
  assign running       = r_running;
  assign ce_a          = r_ce_a;
  assign ce_b          = r_ce_b;
  assign lock_loss_cnt = r_lock_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reset_ce_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_ce_seq
//  Description : Scoreboard bench for reset_ce_seq. Three parameter sets share
//                one stimulus stream. A streak-based reference model pushes
//                expected outputs, and a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_ce_seq;

  typedef struct packed {
    logic       cr;
    logic       run;
    logic       ca;
    logic       cb;
    logic [7:0] llc;
  } exp_t;

  localparam int c_lh [3] = '{8, 8, 1};
  localparam int c_da [3] = '{4, 1, 4};
  localparam int c_db [3] = '{2, 3, 2};

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       ext_reset = 1'b0;
  logic       cr   [3];
  logic       run  [3];
  logic       ca   [3];
  logic       cb   [3];
  logic [7:0] llc  [3];

  always #5 clk_sys = ~clk_sys;

  reset_ce_seq #(.LOCK_HOLD(8), .CE_DIV_A(4), .CE_DIV_B(2)) u_dut0 (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked), .ext_reset(ext_reset),
    .core_reset(cr[0]), .running(run[0]), .ce_a(ca[0]), .ce_b(cb[0]), .lock_loss_cnt(llc[0]));
  reset_ce_seq #(.LOCK_HOLD(8), .CE_DIV_A(1), .CE_DIV_B(3)) u_dut1 (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked), .ext_reset(ext_reset),
    .core_reset(cr[1]), .running(run[1]), .ce_a(ca[1]), .ce_b(cb[1]), .lock_loss_cnt(llc[1]));
  reset_ce_seq #(.LOCK_HOLD(1), .CE_DIV_A(4), .CE_DIV_B(2)) u_dut2 (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked), .ext_reset(ext_reset),
    .core_reset(cr[2]), .running(run[2]), .ce_a(ca[2]), .ce_b(cb[2]), .lock_loss_cnt(llc[2]));

  // Reference model state: the last two lock samples, the length of the
  // current run of "good" edges, the index of the current RUN cycle, and the
  // lock-loss count.
  bit   m_s1 [3];
  bit   m_s2 [3];
  bit   m_run [3];
  int   m_streak [3];
  int   m_k [3];
  int   m_llc [3];

  exp_t q[$];
  bit   active = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // The core runs once the good streak reaches LOCK_HOLD+1 edges, and keeps
  // running while the streak continues.
  task automatic model_edge(input int i, input bit r, input bit p, input bit e);
    bit ls;
    bit was;
    if (r) begin
      m_s1[i] = 0; m_s2[i] = 0; m_run[i] = 0;
      m_streak[i] = 0; m_k[i] = 0; m_llc[i] = 0;
    end else begin
      ls  = m_s2[i];
      was = m_run[i];
      if (ls && !e) m_streak[i] = (m_streak[i] < 1000000) ? m_streak[i] + 1 : m_streak[i];
      else          m_streak[i] = 0;
      m_run[i] = (m_streak[i] >= c_lh[i] + 1);
      if (was && !ls && m_llc[i] < 255) m_llc[i] = m_llc[i] + 1;
      m_k[i]  = (was && m_run[i]) ? m_k[i] + 1 : 0;
      m_s2[i] = m_s1[i];
      m_s1[i] = p;
    end
  endtask

  function automatic exp_t model_out(input int i);
    exp_t x;
    x.cr  = !m_run[i];
    x.run = m_run[i];
    x.ca  = m_run[i] && ((m_k[i] % c_da[i]) == c_da[i] - 1);
    x.cb  = m_run[i] && ((m_k[i] % c_db[i]) == c_db[i] - 1);
    x.llc = 8'(m_llc[i]);
    return x;
  endfunction

  // Drive one cycle of inputs and push the outputs expected after the next edge.
  task automatic step(input bit r, input bit p, input bit e);
    @(negedge clk_sys);
    reset = r; pll_locked = p; ext_reset = e;
    for (int i = 0; i < 3; i++) begin
      model_edge(i, r, p, e);
      q.push_back(model_out(i));
    end
    active = 1'b1;
  endtask

  // Monitor: after each edge, pop one expectation per instance and compare.
  initial begin
    exp_t ex;
    exp_t got;
    forever begin
      @(posedge clk_sys);
      #1;
      if (active) begin
        for (int i = 0; i < 3; i++) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty inst%0d t=%0t: got no expectation, required one", i, $time);
          end else begin
            ex  = q.pop_front();
            got = '{cr: cr[i], run: run[i], ca: ca[i], cb: cb[i], llc: llc[i]};
            if (got !== ex) begin
              n_err++;
              $display("FAIL outputs inst%0d t=%0t: got cr=%b run=%b ce_a=%b ce_b=%b llc=%0d, required cr=%b run=%b ce_a=%b ce_b=%b llc=%0d",
                       i, $time, got.cr, got.run, got.ca, got.cb, got.llc,
                       ex.cr, ex.run, ex.ca, ex.cb, ex.llc);
            end
          end
        end
      end
    end
  end

  initial begin
    // Power-up with the lock already present.
    repeat (2) step(1, 1, 0);
    repeat (40) step(0, 1, 0);
    // A one-cycle ext_reset pulse while running.
    step(0, 1, 1);
    repeat (20) step(0, 1, 0);
    // Lock loss while running, then re-lock.
    repeat (2) step(0, 0, 0);
    repeat (20) step(0, 1, 0);
    // Lock loss coinciding with ext_reset.
    repeat (2) step(0, 0, 0);
    step(0, 0, 1);
    repeat (20) step(0, 1, 0);
    // Glitchy lock during COUNT.
    repeat (2) step(1, 1, 0);
    repeat (5) step(0, 1, 0);
    step(0, 0, 0);
    repeat (30) step(0, 1, 0);
    // Mid-RUN reset.
    step(1, 1, 0);
    repeat (12) step(0, 1, 0);
    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 29) != 0),
           ($urandom_range(0, 59) == 0));
    end
    // Saturate the lock-loss counter (LOCK_HOLD=1 instance), then reset.
    repeat (2) step(1, 1, 0);
    repeat (6) step(0, 1, 0);
    for (int n = 0; n < 262; n++) begin
      step(0, 0, 0);
      repeat (4) step(0, 1, 0);
    end
    repeat (2) step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    @(posedge clk_sys);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reset_ce_seq.md
RESET_CE_SEQ -- requirements
Module: reset_ce_seq

Interface
REQ-001 SHALL have parameter LOCK_HOLD, default 1024, meaning consecutive synchronized-lock cycles required before core reset release (legal >= 1).
REQ-002 SHALL have parameter CE_DIV_A, default 4, meaning the ce_a period in clk_sys cycles (legal >= 1); 16 MHz to 4 MHz.
REQ-003 SHALL have parameter CE_DIV_B, default 2, meaning the ce_b period in clk_sys cycles (legal >= 1).
REQ-004 SHALL have port clk_sys, input, 1: the single clock, driven by the 16 MHz PLL output; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port pll_locked, input, 1: PLL lock status, asynchronous to clk_sys.
REQ-007 SHALL have port ext_reset, input, 1: user/OSD core reset request, synchronous to clk_sys.
REQ-008 SHALL have port core_reset, output, 1: registered active-high reset to the game core.
REQ-009 SHALL have port running, output, 1: high while state is RUN.
REQ-010 SHALL have port ce_a, output, 1: single-cycle clock enable, period CE_DIV_A.
REQ-011 SHALL have port ce_b, output, 1: single-cycle clock enable, period CE_DIV_B.
REQ-012 SHALL have port lock_loss_cnt, output, 8: count of RUN-state lock losses.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer to lock_s; no other logic samples pll_locked.
REQ-014 SHALL implement states HOLD, COUNT, RUN.
REQ-015 HOLD: core_reset=1, hold counter=0; go to COUNT when lock_s=1 and ext_reset=0.
REQ-016 COUNT: core_reset=1, hold counter increments each cycle; go to HOLD if lock_s=0 or ext_reset=1, clearing the counter.
REQ-017 COUNT: go to RUN at the edge where the counter equals LOCK_HOLD-1, lock_s=1 and ext_reset=0.
REQ-018 RUN: core_reset=0, running=1; go to HOLD on lock_s=0 or ext_reset=1.
REQ-019 On simultaneous lock loss and ext_reset, RUN SHALL go to HOLD once, with a single lock_loss_cnt increment.
REQ-020 core_reset and running SHALL be registered and change on the same edge as the state change.
REQ-021 With pll_locked high before edge 1, core_reset SHALL fall at edge LOCK_HOLD+3: 2 sync edges, 1 HOLD->COUNT edge, LOCK_HOLD count edges.
REQ-022 Divider counters A and B SHALL be 0 outside RUN and count modulo CE_DIV_x in RUN, starting at 0 on RUN entry.
REQ-023 ce_x SHALL be high only in RUN when the counter equals CE_DIV_x-1; the first pulse is in RUN cycle CE_DIV_x-1 (0-based), then every CE_DIV_x cycles.
REQ-024 CE_DIV_x=1 SHALL hold ce_x continuously high throughout RUN.
REQ-025 ce_a and ce_b SHALL be low in the same cycle core_reset is high; no partial pulse after leaving RUN.
REQ-026 lock_loss_cnt SHALL increment on each RUN->HOLD transition caused by lock_s=0, saturating at 255.
REQ-027 ext_reset SHALL NOT increment lock_loss_cnt.

Reset
REQ-028 reset SHALL set state=HOLD, synchronizer flops=0, all counters=0, core_reset=1, running=0, ce_a=0, ce_b=0, lock_loss_cnt=0, taking priority over all other inputs.
REQ-029 reset asserted mid-COUNT or mid-RUN SHALL yield the REQ-028 values after the next edge; lock_loss_cnt SHALL NOT increment.

Verification (LOCK_HOLD=8, CE_DIV_A=4, CE_DIV_B=2 unless stated)
REQ-030 Power-up: reset 2 cycles, pll_locked=1 -> core_reset falls at edge 11 after reset release; ce_a pulses at RUN cycles 3,7,11; ce_b at 1,3,5.
REQ-031 Glitchy lock: pll_locked high 5 cycles, low 1, high -> COUNT aborts to HOLD; release occurs LOCK_HOLD+3 edges after the final rise; lock_loss_cnt=0.
REQ-032 Lock loss in RUN: drop pll_locked -> core_reset high 3 edges later, ce_a/ce_b low the same cycle, lock_loss_cnt=1; re-lock -> release after LOCK_HOLD+3 edges.
REQ-033 ext_reset 1 cycle in RUN -> core_reset high 1 edge later; release 1+LOCK_HOLD edges after ext_reset falls; lock_loss_cnt unchanged.
REQ-034 Saturation: 260 RUN lock losses with LOCK_HOLD=1 -> lock_loss_cnt=255; then reset -> 0.
REQ-035 CE_DIV_A=1, CE_DIV_B=3 -> ce_a constantly high in RUN; ce_b at RUN cycles 2,5,8.
